// File: rtl/pcie_egress_arbiter.sv
// Packet-granular round-robin arbiter that feeds three AXI-Stream sources into the PCIe egress input.
// A grant is issued only below the FIFO high-water mark and is held until the granted source's TLAST beat.
module pcie_egress_arbiter #(
  parameter logic [31:0] HIGH_WATER = 32'd448
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        S0_AXIS_TVALID,
  output logic        S0_AXIS_TREADY,
  input  logic [31:0] S0_AXIS_TDATA,
  input  logic [3:0]  S0_AXIS_TKEEP,
  input  logic        S0_AXIS_TLAST,
  input  logic        S1_AXIS_TVALID,
  output logic        S1_AXIS_TREADY,
  input  logic [31:0] S1_AXIS_TDATA,
  input  logic [3:0]  S1_AXIS_TKEEP,
  input  logic        S1_AXIS_TLAST,
  input  logic        S2_AXIS_TVALID,
  output logic        S2_AXIS_TREADY,
  input  logic [31:0] S2_AXIS_TDATA,
  input  logic [3:0]  S2_AXIS_TKEEP,
  input  logic        S2_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic [3:0]  M_AXIS_TKEEP,
  output logic        M_AXIS_TLAST,
  input  logic [31:0] FIFO_DATA_COUNT,
  output logic [2:0]  GRANT,
  output logic        BUSY,
  output logic [31:0] PACKET_COUNT
);

  localparam int unsigned NUM_SRC = 3;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t      state_q;
  logic [2:0]  grant_q;
  logic [1:0]  rr_last_q;
  logic [31:0] packet_count_q;
  logic [31:0] packet_count_d;

  logic [2:0]  s_valid;
  logic        eligible;
  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic [1:0]  grant_idx;
  logic        pkt_done;

  assign s_valid = {S2_AXIS_TVALID, S1_AXIS_TVALID, S0_AXIS_TVALID};

  // (base + k) mod 3 for base in 0..2, k in 1..3
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] s;
    s = 3'(base) + 3'(k);
    return (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
  endfunction

  // First valid source after the last one served; lowest offset wins
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (s_valid[rr_add(rr_last_q, 2'(k))]) begin
        pick_vld = 1'b1;
        pick_idx = rr_add(rr_last_q, 2'(k));
      end
    end
  end

  assign eligible = pick_vld && (FIFO_DATA_COUNT < HIGH_WATER);

  // Pass-through mux of the granted source; grant_q is zero outside STREAM
  always_comb begin
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = 32'd0;
    M_AXIS_TKEEP  = 4'd0;
    M_AXIS_TLAST  = 1'b0;
    grant_idx     = 2'd0;
    unique case (grant_q)
      3'b001: begin
        M_AXIS_TVALID = S0_AXIS_TVALID;
        M_AXIS_TDATA  = S0_AXIS_TDATA;
        M_AXIS_TKEEP  = S0_AXIS_TKEEP;
        M_AXIS_TLAST  = S0_AXIS_TLAST;
        grant_idx     = 2'd0;
      end
      3'b010: begin
        M_AXIS_TVALID = S1_AXIS_TVALID;
        M_AXIS_TDATA  = S1_AXIS_TDATA;
        M_AXIS_TKEEP  = S1_AXIS_TKEEP;
        M_AXIS_TLAST  = S1_AXIS_TLAST;
        grant_idx     = 2'd1;
      end
      3'b100: begin
        M_AXIS_TVALID = S2_AXIS_TVALID;
        M_AXIS_TDATA  = S2_AXIS_TDATA;
        M_AXIS_TKEEP  = S2_AXIS_TKEEP;
        M_AXIS_TLAST  = S2_AXIS_TLAST;
        grant_idx     = 2'd2;
      end
      default: ;
    endcase
  end

  assign S0_AXIS_TREADY = grant_q[0] & M_AXIS_TREADY;
  assign S1_AXIS_TREADY = grant_q[1] & M_AXIS_TREADY;
  assign S2_AXIS_TREADY = grant_q[2] & M_AXIS_TREADY;

  assign pkt_done       = (state_q == STREAM) && M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;
  assign packet_count_d = pkt_done ? packet_count_q + 32'd1 : packet_count_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q        <= IDLE;
      grant_q        <= 3'b000;
      rr_last_q      <= 2'd2;
      packet_count_q <= 32'd0;
    end else begin
      packet_count_q <= packet_count_d;
      unique case (state_q)
        IDLE: begin
          if (eligible) begin
            state_q <= STREAM;
            grant_q <= 3'b001 << pick_idx;
          end
        end
        STREAM: begin
          if (pkt_done) begin
            state_q   <= IDLE;
            grant_q   <= 3'b000;
            rr_last_q <= grant_idx;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 3'b000;
        end
      endcase
    end
  end

  assign GRANT        = grant_q;
  assign BUSY         = (state_q == STREAM);
  assign PACKET_COUNT = packet_count_q;

endmodule

// File: tb/tb_pcie_egress_arbiter.sv
// Scoreboard bench for pcie_egress_arbiter: expected beats are queued in expected grant order
// and checked against every accepted M_AXIS beat.
module tb_pcie_egress_arbiter;

  typedef struct {
    int          src;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        s_tvalid [3];
  logic        s_tready [3];
  logic [31:0] s_tdata  [3];
  logic [3:0]  s_tkeep  [3];
  logic        s_tlast  [3];
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TLAST;
  logic [31:0] FIFO_DATA_COUNT;
  logic [2:0]  GRANT;
  logic        BUSY;
  logic [31:0] PACKET_COUNT;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  bit    prev_last = 0;

  always #5 ACLK = ~ACLK;

  pcie_egress_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S0_AXIS_TVALID(s_tvalid[0]), .S0_AXIS_TREADY(s_tready[0]), .S0_AXIS_TDATA(s_tdata[0]),
    .S0_AXIS_TKEEP(s_tkeep[0]), .S0_AXIS_TLAST(s_tlast[0]),
    .S1_AXIS_TVALID(s_tvalid[1]), .S1_AXIS_TREADY(s_tready[1]), .S1_AXIS_TDATA(s_tdata[1]),
    .S1_AXIS_TKEEP(s_tkeep[1]), .S1_AXIS_TLAST(s_tlast[1]),
    .S2_AXIS_TVALID(s_tvalid[2]), .S2_AXIS_TREADY(s_tready[2]), .S2_AXIS_TDATA(s_tdata[2]),
    .S2_AXIS_TKEEP(s_tkeep[2]), .S2_AXIS_TLAST(s_tlast[2]),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
    .FIFO_DATA_COUNT(FIFO_DATA_COUNT), .GRANT(GRANT), .BUSY(BUSY), .PACKET_COUNT(PACKET_COUNT)
  );

  // Monitor: compare accepted beats with the scoreboard, ready routing, and the inter-packet bubble
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      prev_last = 0;
    end else begin
      if (prev_last) begin
        tests++;
        if (BUSY !== 1'b0 || M_AXIS_TVALID !== 1'b0) begin
          fails++;
          $display("FAIL bubble: busy=%b m_tvalid=%b, required 0/0", BUSY, M_AXIS_TVALID);
        end
      end
      prev_last = 0;
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (s_tready[i] !== (BUSY && GRANT[i] && M_AXIS_TREADY)) begin
          fails++;
          $display("FAIL tready_route s%0d: got %b grant=%b m_tready=%b", i, s_tready[i], GRANT, M_AXIS_TREADY);
        end
      end
      if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: data=%h with empty scoreboard", M_AXIS_TDATA);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (M_AXIS_TDATA !== e.data || M_AXIS_TKEEP !== e.keep || M_AXIS_TLAST !== e.last ||
              GRANT !== (3'b001 << e.src)) begin
            fails++;
            $display("FAIL beat: got data=%h keep=%b last=%b grant=%b, required data=%h keep=%b last=%b src=%0d",
                     M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, GRANT, e.data, e.keep, e.last, e.src);
          end
          prev_last = M_AXIS_TLAST;
        end
      end
    end
  end

  task automatic push_pkt(input int src, input int n, input logic [31:0] base, input logic [3:0] lk);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.src  = src;
      b.data = base + 32'(i);
      b.keep = (i == n - 1) ? lk : 4'hF;
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_hs(input int src, output bit ok);
    bit hs;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge ACLK);
      hs = (s_tready[src] === 1'b1);
      @(posedge ACLK);
      #1;
      if (hs) begin
        ok = 1;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL handshake_timeout s%0d: no TREADY within 300 cycles", src);
  endtask

  task automatic send_pkt(input int src, input int n, input logic [31:0] base, input logic [3:0] lk,
                          input int gap_beat, input int gap_len);
    bit ok;
    for (int i = 0; i < n; i++) begin
      s_tvalid[src] = 1'b1;
      s_tdata[src]  = base + 32'(i);
      s_tkeep[src]  = (i == n - 1) ? lk : 4'hF;
      s_tlast[src]  = (i == n - 1);
      wait_hs(src, ok);
      if (!ok) begin
        s_tvalid[src] = 1'b0;
        return;
      end
      if (i == gap_beat) begin
        s_tvalid[src] = 1'b0;
        repeat (gap_len) @(posedge ACLK);
        #1;
      end
    end
    s_tvalid[src] = 1'b0;
    s_tlast[src]  = 1'b0;
  endtask

  task automatic apply_reset();
    ARESETN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_tvalid[i] = 1'b0;
      s_tlast[i]  = 1'b0;
    end
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
  endtask

  task automatic check_empty(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_leftover: %0d beats never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    tests++;
    if (GRANT !== 3'b000 || BUSY !== 1'b0 || PACKET_COUNT !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: grant=%b busy=%b count=%0d, required 000/0/0", GRANT, BUSY, PACKET_COUNT);
    end
    tests++;
    if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TDATA !== 32'd0 || M_AXIS_TKEEP !== 4'd0 || M_AXIS_TLAST !== 1'b0) begin
      fails++;
      $display("FAIL reset_m_axis: v=%b d=%h k=%b l=%b, required all zero", M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST);
    end
    tests++;
    if (s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0 || s_tready[2] !== 1'b0) begin
      fails++;
      $display("FAIL reset_tready: %b%b%b, required 000", s_tready[2], s_tready[1], s_tready[0]);
    end
    ARESETN = 1'b1;
  endtask

  task automatic test_single_source();
    apply_reset();
    push_pkt(1, 4, 32'h1100_0000, 4'hF);
    fork
      send_pkt(1, 4, 32'h1100_0000, 4'hF, -1, 0);
      begin
        @(posedge ACLK);
        #1;
        tests++;
        if (GRANT !== 3'b010 || BUSY !== 1'b1) begin
          fails++;
          $display("FAIL s1_grant_latency: grant=%b busy=%b, required 010/1", GRANT, BUSY);
        end
      end
    join
    tests++;
    if (PACKET_COUNT !== 32'd1 || BUSY !== 1'b0 || GRANT !== 3'b000) begin
      fails++;
      $display("FAIL s1_done: count=%0d busy=%b grant=%b, required 1/0/000", PACKET_COUNT, BUSY, GRANT);
    end
    check_empty("s1");
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 3; s++)
        push_pkt(s, 2, {8'(s), 8'(r), 16'h0}, 4'hF);
    fork
      begin send_pkt(0, 2, 32'h0000_0000, 4'hF, -1, 0); send_pkt(0, 2, 32'h0001_0000, 4'hF, -1, 0); end
      begin send_pkt(1, 2, 32'h0100_0000, 4'hF, -1, 0); send_pkt(1, 2, 32'h0101_0000, 4'hF, -1, 0); end
      begin send_pkt(2, 2, 32'h0200_0000, 4'hF, -1, 0); send_pkt(2, 2, 32'h0201_0000, 4'hF, -1, 0); end
    join
    @(posedge ACLK);
    #1;
    tests++;
    if (PACKET_COUNT !== 32'd6) begin
      fails++;
      $display("FAIL rr_count: got %0d, required 6", PACKET_COUNT);
    end
    check_empty("rr");
  endtask

  task automatic test_watermark();
    apply_reset();
    FIFO_DATA_COUNT = 32'd448;
    push_pkt(0, 1, 32'hAAAA_0000, 4'hF);
    fork
      send_pkt(0, 1, 32'hAAAA_0000, 4'hF, -1, 0);
      begin
        repeat (3) @(posedge ACLK);
        #1;
        tests++;
        if (GRANT !== 3'b000 || s_tready[0] !== 1'b0) begin
          fails++;
          $display("FAIL wm_block: grant=%b s0_tready=%b at count 448, required 000/0", GRANT, s_tready[0]);
        end
        FIFO_DATA_COUNT = 32'd447;
        @(posedge ACLK);
        #1;
        tests++;
        if (GRANT !== 3'b001) begin
          fails++;
          $display("FAIL wm_permit: grant=%b at count 447, required 001", GRANT);
        end
      end
    join
    FIFO_DATA_COUNT = 32'd0;
    check_empty("wm");
  endtask

  task automatic test_gap_backpressure();
    bit done = 0;
    apply_reset();
    push_pkt(2, 4, 32'h2222_0000, 4'b0011);
    fork
      begin send_pkt(2, 4, 32'h2222_0000, 4'b0011, 0, 3); done = 1; end
      begin
        int t = 0;
        while (!done) begin
          M_AXIS_TREADY = (t % 2 == 0);
          t++;
          @(posedge ACLK);
          #1;
        end
        M_AXIS_TREADY = 1'b1;
      end
      begin
        repeat (6) @(negedge ACLK);
        tests++;
        if (GRANT !== 3'b100 || BUSY !== 1'b1 || M_AXIS_TVALID !== 1'b0) begin
          fails++;
          $display("FAIL gap_hold: grant=%b busy=%b m_tvalid=%b, required 100/1/0", GRANT, BUSY, M_AXIS_TVALID);
        end
      end
    join
    tests++;
    if (PACKET_COUNT !== 32'd1 || GRANT !== 3'b000) begin
      fails++;
      $display("FAIL gap_done: count=%0d grant=%b, required 1/000", PACKET_COUNT, GRANT);
    end
    check_empty("gap");
  endtask

  task automatic test_reset_mid_packet();
    push_pkt(0, 1, 32'h5050_0000, 4'hF);
    send_pkt(0, 1, 32'h5050_0000, 4'hF, -1, 0);
    s_tvalid[0] = 1'b1;
    s_tdata[0]  = 32'h5151_0000;
    s_tkeep[0]  = 4'hF;
    s_tlast[0]  = 1'b0;
    push_pkt(0, 1, 32'h5151_0000, 4'hF);
    exp_q[exp_q.size() - 1].last = 1'b0;
    @(posedge ACLK);
    #1;
    tests++;
    if (GRANT !== 3'b001) begin
      fails++;
      $display("FAIL mid_grant: grant=%b, required 001", GRANT);
    end
    @(posedge ACLK);
    #1;
    s_tdata[0] = 32'h5151_0001;
    ARESETN    = 1'b0;
    @(posedge ACLK);
    #1;
    tests++;
    if (GRANT !== 3'b000 || M_AXIS_TVALID !== 1'b0 || PACKET_COUNT !== 32'd0 ||
        s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0 || s_tready[2] !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: grant=%b m_tvalid=%b count=%0d tready=%b%b%b, required 000/0/0/000",
               GRANT, M_AXIS_TVALID, PACKET_COUNT, s_tready[2], s_tready[1], s_tready[0]);
    end
    s_tvalid[0] = 1'b0;
    ARESETN     = 1'b1;
    check_empty("mid");
    push_pkt(0, 2, 32'h6060_0000, 4'hF);
    push_pkt(1, 1, 32'h6161_0000, 4'hF);
    fork
      send_pkt(0, 2, 32'h6060_0000, 4'hF, -1, 0);
      send_pkt(1, 1, 32'h6161_0000, 4'hF, -1, 0);
      begin
        @(posedge ACLK);
        #1;
        tests++;
        if (GRANT !== 3'b001) begin
          fails++;
          $display("FAIL mid_rr_restart: grant=%b, required 001", GRANT);
        end
      end
    join
    check_empty("mid_after");
  endtask

  task automatic test_count_wrap();
    force dut.packet_count_q = 32'hFFFF_FFFF;
    @(negedge ACLK);
    release dut.packet_count_q;
    push_pkt(2, 1, 32'h7777_0000, 4'b0001);
    send_pkt(2, 1, 32'h7777_0000, 4'b0001, -1, 0);
    tests++;
    if (PACKET_COUNT !== 32'd0) begin
      fails++;
      $display("FAIL count_wrap: got %h, required 00000000", PACKET_COUNT);
    end
    check_empty("wrap");
  endtask

  initial begin
    ARESETN         = 1'b0;
    M_AXIS_TREADY   = 1'b1;
    FIFO_DATA_COUNT = 32'd0;
    for (int i = 0; i < 3; i++) begin
      s_tvalid[i] = 1'b0;
      s_tdata[i]  = 32'd0;
      s_tkeep[i]  = 4'd0;
      s_tlast[i]  = 1'b0;
    end
    @(posedge ACLK);
    #1;
    test_reset();
    test_single_source();
    test_round_robin();
    test_watermark();
    test_gap_backpressure();
    test_reset_mid_packet();
    test_count_wrap();
    repeat (3) @(posedge ACLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
